// File: rtl/nc_fetch_responder_pkg.sv
// Shared types and constants for the non-cacheable instruction-fetch responder.
package nc_fetch_responder_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } nc_fetch_state_t;

  localparam int NcAddrWidth   = 40;
  localparam int NcLineBytes   = 32;
  localparam int NcLineLsb     = $clog2(NcLineBytes);
  localparam int NcDwordSelMsb = 4;
  localparam int NcDwordSelLsb = 3;

  typedef struct packed {
    logic                   valid;
    logic [NcAddrWidth-1:0] vaddr;
  } nc_fetch_req_t;

  // Bit offset of the selected 64-bit dword inside a 256-bit line.
  function automatic int unsigned nc_dword_lsb(input logic [1:0] sel);
    return {24'd0, sel, 6'd0};
  endfunction

endpackage

// File: rtl/nc_fetch_responder_req_fifo.sv
// Request buffer: power-of-two depth, extra pointer MSB distinguishes full from empty.
module nc_req_fifo #(
  parameter int Depth = 2,
  parameter int Width = 37
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(Depth);

  logic [PtrW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[PtrW-1:0]] = wdata_i;
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/nc_fetch_responder.sv
// Responder for non-cacheable instruction fetches: buffers pulses, reads the 32-byte
// line from memory and returns exactly one grant per request (error grant on timeout/drop).
//   state | meaning
//   IDLE  | pop next request, else emit an owed error grant
//   REQ   | line read presented to memory
//   WAIT  | waiting for line data, timeout running
//   RESP  | grant with captured dword or timeout error
//   ERR   | error grant for a request dropped on overflow
module nc_fetch_responder
  import nc_fetch_responder_pkg::*;
#(
  parameter int FifoDepth     = 2,
  parameter int TimeoutCycles = 1024,
  parameter int AddrWidth     = 40
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 req_nc_valid_i,
  input  logic [AddrWidth-1:0] req_nc_vaddr_i,
  output logic                 l2_grant_valid_o,
  output logic [255:0]         l2_resp_data_o,
  output logic                 l2_resp_err_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [AddrWidth-1:0] mem_req_addr_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [255:0]         mem_rsp_data_i,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int TimerW = $clog2(TimeoutCycles) + 1;
  localparam int OwedW  = $clog2(FifoDepth) + 1;

  nc_fetch_state_t                      state_q, state_d;
  logic [AddrWidth-1:NcDwordSelLsb]     addr_q, addr_d;
  logic [TimerW-1:0]                    timer_q, timer_d;
  logic [OwedW-1:0]                     owed_q, owed_d;
  logic                                 grant_q, grant_d;
  logic [63:0]                          data_q, data_d;
  logic                                 err_q, err_d;
  logic                                 mem_req_valid_q, mem_req_valid_d;
  logic                                 overflow_q, overflow_d;

  logic [AddrWidth-1:NcDwordSelLsb]     fifo_rdata;
  logic                                 fifo_full, fifo_empty, fifo_pop;
  logic                                 drop, owed_inc, owed_dec;
  logic                                 unused_vaddr_lsbs;

  // Requests are dword aligned, so the low address bits carry no information.
  assign unused_vaddr_lsbs = ^req_nc_vaddr_i[NcDwordSelLsb-1:0];

  nc_req_fifo #(
    .Depth (FifoDepth),
    .Width (AddrWidth - NcDwordSelLsb)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (req_nc_valid_i),
    .wdata_i (req_nc_vaddr_i[AddrWidth-1:NcDwordSelLsb]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign drop     = req_nc_valid_i && fifo_full && !fifo_pop;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    timer_d         = timer_q;
    grant_d         = 1'b0;
    data_d          = data_q;
    err_d           = err_q;
    mem_req_valid_d = mem_req_valid_q;
    overflow_d      = overflow_q | drop;
    owed_dec        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          addr_d          = fifo_rdata;
          mem_req_valid_d = 1'b1;
          state_d         = REQ;
        end else if (owed_q != '0) begin
          grant_d = 1'b1;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          timer_d         = '0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        // Data arriving on the final timeout cycle still counts as a real response.
        if (mem_rsp_valid_i) begin
          data_d  = mem_rsp_data_i[nc_dword_lsb(addr_q[NcDwordSelMsb:NcDwordSelLsb]) +: 64];
          err_d   = 1'b0;
          grant_d = 1'b1;
          state_d = RESP;
        end else if (timer_q == TimerW'(TimeoutCycles - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          grant_d = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      ERR: begin
        owed_dec = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    owed_inc = drop && ((owed_q != OwedW'(FifoDepth)) || owed_dec);
    owed_d   = owed_q + OwedW'(owed_inc) - OwedW'(owed_dec);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      timer_q         <= '0;
      owed_q          <= '0;
      grant_q         <= 1'b0;
      data_q          <= '0;
      err_q           <= 1'b0;
      mem_req_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      timer_q         <= timer_d;
      owed_q          <= owed_d;
      grant_q         <= grant_d;
      data_q          <= data_d;
      err_q           <= err_d;
      mem_req_valid_q <= mem_req_valid_d;
      overflow_q      <= overflow_d;
    end
  end

  assign l2_grant_valid_o = grant_q;
  assign l2_resp_data_o   = {192'd0, data_q};
  assign l2_resp_err_o    = err_q;
  assign mem_req_valid_o  = mem_req_valid_q;
  assign mem_req_addr_o   = {addr_q[AddrWidth-1:NcLineLsb], {NcLineLsb{1'b0}}};
  assign overflow_o       = overflow_q;
  assign busy_o           = !fifo_empty || (state_q != IDLE);

endmodule
